pad_event_fifo: RTL and testbench
=================================

# pad_event_fifo

Downstream stage of the pad debouncer. It captures the four one-cycle debounced button ticks (S, R, L, D) and serialises simultaneous presses in a fixed priority order. Events are buffered in a small show-ahead FIFO and handed to game logic over a valid/ready handshake, so no press is lost while the consumer is busy, for example while it waits for a frame boundary.

## Interface

- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- ADDR_W, 3: log2(DEPTH).

- pclk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low. Asserting it immediately forces all state to reset values.
- pad_Sd  in  1  debounced Start tick, one-cycle pulse.
- pad_Rd  in  1  debounced Right tick.
- pad_Ld  in  1  debounced Left tick.
- pad_Dd  in  1  debounced Down tick.
- cmd_ready  in  1  consumer accepts head entry this cycle.
- clr_overflow  in  1  clears the sticky overflow flag.
- cmd_valid  out  1  FIFO non-empty; cmd_code is valid.
- cmd_code  out  2  head event: 0=S, 1=R, 2=L, 3=D.
- fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a press was coalesced because it could not be queued.

## Operation

- **Pending register** pend[3:0]: bit0=S, bit1=R, bit2=L, bit3=D.
  - On each edge, pend |= incoming ticks.
  - A tick whose pend bit is already 1 and is not being drained this cycle is coalesced: it is lost, and overflow is set.
- **Drain**
  - Each cycle, at most one pending bit is transferred into the FIFO.
  - Priority is S > D > L > R.
  - A transfer occurs when pend ≠ 0 and either fifo_count < DEPTH or a pop happens in the same cycle.
  - The transferred bit is cleared.
  - If a new tick for that same bit arrives in the same cycle, the set wins: the bit stays 1 and nothing is lost.
- **FIFO**
  - Circular buffer with ADDR_W-bit read and write pointers that wrap naturally from DEPTH−1 to 0.
  - fifo_count is kept as a separate ADDR_W+1-bit counter.
  - Push only: count +1. Pop only: count −1. Push and pop together: count unchanged.
- **Output and pop**
  - Show-ahead: cmd_code = mem[rd_ptr].
  - cmd_valid = (fifo_count ≠ 0).
  - A pop occurs when cmd_valid & cmd_ready.
  - cmd_ready while empty has no effect.
  - cmd_code is don't-care when cmd_valid = 0; the implementation drives it 0.
- **Full**
  - When full with no pop, pend holds its contents and no entry is overwritten.
  - Overflow is flagged only on a coalesced tick, not on the stall itself.
- **overflow flag**
  - Set on any coalesce.
  - clr_overflow clears it.
  - If a set and clr_overflow occur in the same cycle, the set wins.

## Timing

- Reset values: pend=0, pointers=0, fifo_count=0, cmd_valid=0, cmd_code=0, overflow=0.
- Latency: a tick high in cycle n sets pend at edge n+1.
  - If it is the highest pending priority and space exists, it is pushed at edge n+2.
  - cmd_valid then rises in cycle n+2.
- Simultaneous ticks S,R,L,D in one cycle produce pushes on 4 consecutive edges in the order S, D, L, R.
- Sustained throughput is one push and one pop per cycle.
- Pop at edge k: the next entry appears on cmd_code in cycle k (the cycle after edge k). There is no bubble.
- cmd_valid, cmd_code, fifo_count and overflow are all registered outputs or direct decodes of registers. There are no combinational paths from any input to any output.
- Reset asserted mid-operation discards all pending and queued events asynchronously. Operation resumes on the first edge after deassertion.

## Test plan

- **Reset:** hold rst=0 while driving ticks, release rst.
  - Required: cmd_valid=0, fifo_count=0 and overflow=0 throughout.
  - Required: the first single pad_Ld tick afterwards gives cmd_valid high 2 cycles later with cmd_code=2.
- **Simultaneous:** all four ticks pulse in the same cycle, cmd_ready=0.
  - Required: fifo_count steps 1,2,3,4 on consecutive edges.
  - Required: popping then yields codes 0,3,2,1.
- **Full/stall:** cmd_ready=0, issue 8 separate pad_Rd ticks spaced 3 cycles apart.
  - Required: fifo_count=8, overflow=0.
  - Then issue a pad_Sd tick. Required: pend holds it.
  - Then issue another pad_Sd tick. Required: overflow=1.
  - Then raise cmd_ready for one cycle. Required: code 1 popped and S pushed in the same edge, fifo_count stays 8.
- **Streaming:** cmd_ready=1 constantly, pad_Dd ticks every cycle for 20 cycles.
  - Required: fifo_count never exceeds 1.
  - Required: 20 code-3 pops with no loss and overflow=0.
- **Wrap-around:** push and pop 3·DEPTH+3 alternating codes.
  - Required: order preserved across pointer wrap, fifo_count returns to 0.
- **Overflow clear:** set overflow, then assert clr_overflow in the same cycle as a new coalesce.
  - Required: overflow stays 1.
  - Required: the next clr_overflow alone clears it to 0.

Source files
------------

// File: rtl/pad_event_fifo.sv
// Pad event serialiser: folds debounced button ticks into a pending set,
// drains one per cycle by priority into a show-ahead valid/ready FIFO.
module pad_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              pad_Sd,
  input  logic              pad_Rd,
  input  logic              pad_Ld,
  input  logic              pad_Dd,
  input  logic              cmd_ready,
  input  logic              clr_overflow,
  output logic              cmd_valid,
  output logic [1:0]        cmd_code,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [3:0]        pend;
  logic [3:0]        tick;
  logic [3:0]        sel;
  logic [3:0]        drain;
  logic [1:0]        sel_code;
  logic [1:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop;
  logic              push;
  logic              space;
  logic              coalesce;

  assign tick      = {pad_Dd, pad_Ld, pad_Rd, pad_Sd};
  assign cmd_valid = (fifo_count != '0);
  assign cmd_code  = cmd_valid ? mem[rd_ptr] : 2'd0;
  assign pop       = cmd_valid & cmd_ready;
  assign space     = (fifo_count < FULL) | pop;
  assign push      = (|pend) & space;
  assign drain     = push ? sel : 4'b0000;
  // a tick landing on a bit that stays pending has nowhere to go
  assign coalesce  = |(tick & pend & ~drain);

  always_comb begin
    sel      = 4'b0000;
    sel_code = 2'd0;
    priority case (1'b1)
      pend[0]: begin sel = 4'b0001; sel_code = 2'd0; end
      pend[3]: begin sel = 4'b1000; sel_code = 2'd3; end
      pend[2]: begin sel = 4'b0100; sel_code = 2'd2; end
      pend[1]: begin sel = 4'b0010; sel_code = 2'd1; end
      default: begin sel = 4'b0000; sel_code = 2'd0; end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= sel_code;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pend       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      pend <= (pend & ~drain) | tick;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (coalesce)          overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pad_event_fifo.sv
// Directed bench for pad_event_fifo: vector table plus
// hand-written stall, streaming, wrap and overflow sequences.
module tb_pad_event_fifo;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       pad_Sd = 1'b0;
  logic       pad_Rd = 1'b0;
  logic       pad_Ld = 1'b0;
  logic       pad_Dd = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [3:0] fifo_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail = 0;

  bit mon_en = 1'b0;
  int exp_q[$];
  int pops = 0;
  int max_cnt = 0;

  typedef struct {
    logic [3:0] tick;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic [1:0] exp_code;
    logic [3:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[9];

  pad_event_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .pclk(pclk),
    .rst(rst),
    .pad_Sd(pad_Sd),
    .pad_Rd(pad_Rd),
    .pad_Ld(pad_Ld),
    .pad_Dd(pad_Dd),
    .cmd_ready(cmd_ready),
    .clr_overflow(clr_overflow),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_ticks(logic [3:0] t);
    {pad_Dd, pad_Ld, pad_Rd, pad_Sd} = t;
  endtask

  always @(negedge pclk) begin
    if (mon_en) begin
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (cmd_valid && cmd_ready) begin
        pops++;
        if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
        else check("pop_code", 32'(cmd_code), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drain(string name);
    int k;
    k = 0;
    cmd_ready = 1'b1;
    while ((exp_q.size() != 0 || fifo_count != 0) && k < 100) begin
      step();
      k++;
    end
    cmd_ready = 1'b0;
    check({name, "_timeout"}, 32'(k < 100), 1);
    check({name, "_empty"}, 32'(fifo_count), 0);
  endtask

  initial begin
    // simultaneous ticks drain S,D,L,R then pop in that order
    tbl[0] = '{4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[1] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[2] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd2, 1'b0};
    tbl[3] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd3, 1'b0};
    tbl[4] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd4, 1'b0};
    tbl[5] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'd3, 1'b0};
    tbl[6] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'd2, 1'b0};
    tbl[7] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'd1, 1'b0};
    tbl[8] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};

    // reset held while ticks arrive
    for (int i = 0; i < 4; i++) begin
      set_ticks(4'b1111);
      cmd_ready = i[0];
      step();
      check("rst_valid", 32'(cmd_valid), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_ovf", 32'(overflow), 0);
    end
    set_ticks(4'b0000);
    cmd_ready = 1'b0;
    rst = 1'b1;
    step();
    check("post_rst_code", 32'(cmd_code), 0);

    set_ticks(4'b0100);
    step();
    set_ticks(4'b0000);
    check("l_lat1_valid", 32'(cmd_valid), 0);
    step();
    check("l_lat2_valid", 32'(cmd_valid), 1);
    check("l_code", 32'(cmd_code), 2);
    check("l_count", 32'(fifo_count), 1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("l_pop_count", 32'(fifo_count), 0);

    for (int i = 0; i < 9; i++) begin
      set_ticks(tbl[i].tick);
      cmd_ready = tbl[i].ready;
      clr_overflow = tbl[i].clr;
      step();
      check($sformatf("vec%0d_valid", i), 32'(cmd_valid),
            32'(tbl[i].exp_valid));
      check($sformatf("vec%0d_code", i), 32'(cmd_code),
            32'(tbl[i].exp_code));
      check($sformatf("vec%0d_count", i), 32'(fifo_count),
            32'(tbl[i].exp_count));
      check($sformatf("vec%0d_ovf", i), 32'(overflow),
            32'(tbl[i].exp_ovf));
    end
    set_ticks(4'b0000);
    cmd_ready = 1'b0;

    // fill to full with spaced R ticks
    for (int i = 0; i < 8; i++) begin
      pad_Rd = 1'b1;
      step();
      pad_Rd = 1'b0;
      step();
      step();
    end
    check("full_count", 32'(fifo_count), 8);
    check("full_ovf", 32'(overflow), 0);
    pad_Sd = 1'b1;
    step();
    pad_Sd = 1'b0;
    step();
    step();
    check("stall_count", 32'(fifo_count), 8);
    check("stall_ovf", 32'(overflow), 0);
    pad_Sd = 1'b1;
    step();
    pad_Sd = 1'b0;
    check("coalesce_ovf", 32'(overflow), 1);
    check("full_head", 32'(cmd_code), 1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("poppush_count", 32'(fifo_count), 8);
    check("poppush_head", 32'(cmd_code), 1);

    // overflow clear versus simultaneous coalesce
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    pad_Sd = 1'b1;
    step();
    check("hold_ovf", 32'(overflow), 0);
    step();
    check("set_ovf", 32'(overflow), 1);
    clr_overflow = 1'b1;
    step();
    pad_Sd = 1'b0;
    clr_overflow = 1'b0;
    check("set_wins_ovf", 32'(overflow), 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("clr_alone_ovf", 32'(overflow), 0);

    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    pops = 0;
    mon_en = 1'b1;
    drain("full_drain");
    check("full_drain_pops", 32'(pops), 9);

    // streaming D ticks with a always-ready consumer
    exp_q.delete();
    pops = 0;
    max_cnt = 0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pad_Dd = 1'b1;
      exp_q.push_back(3);
      step();
    end
    pad_Dd = 1'b0;
    drain("stream_drain");
    check("stream_pops", 32'(pops), 20);
    check("stream_max_le1", 32'(max_cnt <= 1), 1);
    check("stream_ovf", 32'(overflow), 0);

    // pointer wrap with alternating codes
    exp_q.delete();
    pops = 0;
    for (int i = 0; i < 27; i++) begin
      set_ticks(4'(1 << (i % 4)));
      exp_q.push_back(i % 4);
      cmd_ready = 1'b0;
      step();
      set_ticks(4'b0000);
      cmd_ready = 1'b1;
      step();
    end
    drain("wrap_drain");
    check("wrap_pops", 32'(pops), 27);
    check("wrap_ovf", 32'(overflow), 0);
    mon_en = 1'b0;

    // asynchronous reset mid-operation
    set_ticks(4'b1111);
    step();
    set_ticks(4'b0000);
    step();
    check("pre_arst_count", 32'(fifo_count), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(cmd_valid), 0);
    check("arst_count", 32'(fifo_count), 0);
    step();
    rst = 1'b1;
    step();
    step();
    check("post_arst_count", 32'(fifo_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1);
  end

endmodule
